// File: rtl/maq_h_set.sv
// Hours stage: two BCD digits advanced by the minutes carry, with a manual set mode
// (button increment, hold-to-auto-repeat, blink). Define TWELVE_HOUR_EN for 12 h mode with maqh_pm.
module maq_h_set #(
    parameter int HOLD_TICKS = 2,
    parameter int HOLD_W     = 3
) (
    input  logic       maqm_clock,
    input  logic       reset,
    input  logic       enable_1hz,
    input  logic       inc_min,
    input  logic       maqh_inc_hora,
    input  logic       set_mode,
    input  logic       btn_inc,
    output logic [3:0] maqh_lsd,
    output logic [1:0] maqh_msd,
    output logic       maqh_inc_dia,
    output logic       set_active,
    output logic       blink_on
`ifdef TWELVE_HOUR_EN
    ,
    output logic       maqh_pm
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_IDLE = 2'd1;
    localparam logic [1:0] ST_SET_HELD = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] RST_LSD = 4'd2;
    localparam logic [1:0] RST_MSD = 2'd1;
`else
    localparam logic [3:0] RST_LSD = 4'd0;
    localparam logic [1:0] RST_MSD = 2'd0;
`endif

    localparam int N_SYNC = 2;

    logic [N_SYNC-1:0] raw_in;
    logic [N_SYNC-1:0] sync_vec;
    logic              set_mode_s;
    logic              sync_btn;
    logic              prev_btn_reg;
    logic              btn_rise;
    logic              inc_ev;

    logic [1:0]        state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0]        lsd_reg, inc_lsd;
    logic [1:0]        msd_reg, inc_msd;
    logic              blink_reg, blink_next;
    logic              set_active_reg;
    logic              do_inc;
`ifdef TWELVE_HOUR_EN
    logic              pm_reg, inc_pm;
`endif

    assign raw_in = {btn_inc, set_mode};

    // Two-flop synchronizer per raw asynchronous input
    generate
        for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;
            always_ff @(posedge maqm_clock or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    out_reg  <= 1'b0;
                end else begin
                    meta_reg <= raw_in[gi];
                    out_reg  <= meta_reg;
                end
            end
            assign sync_vec[gi] = out_reg;
        end
    endgenerate

    assign set_mode_s = sync_vec[0];
    assign sync_btn   = sync_vec[1];
    assign btn_rise   = sync_btn & ~prev_btn_reg;
    assign inc_ev     = enable_1hz & inc_min & maqh_inc_hora;

    // Next hour value; out-of-range digits fold back into the legal range
    always_comb begin
        inc_lsd = lsd_reg + 4'd1;
        inc_msd = msd_reg;
`ifdef TWELVE_HOUR_EN
        inc_pm  = pm_reg;
        if (msd_reg != 2'd0 && lsd_reg >= 4'd2) begin
            inc_lsd = 4'd1;
            inc_msd = 2'd0;
        end else if (msd_reg == 2'd1 && lsd_reg == 4'd1) begin
            inc_lsd = 4'd2;
            inc_msd = 2'd1;
            inc_pm  = ~pm_reg;
        end else if (lsd_reg >= 4'd9) begin
            inc_lsd = 4'd0;
            inc_msd = msd_reg + 2'd1;
        end
`else
        if (msd_reg >= 2'd2 && lsd_reg >= 4'd3) begin
            inc_lsd = 4'd0;
            inc_msd = 2'd0;
        end else if (lsd_reg >= 4'd9) begin
            inc_lsd = 4'd0;
            inc_msd = msd_reg + 2'd1;
        end
`endif
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        do_inc        = 1'b0;
        case (state_reg)
            ST_RUN: begin
                do_inc = inc_ev;
                if (set_mode_s) state_next = ST_SET_IDLE;
            end
            ST_SET_IDLE: begin
                // Leaving set mode wins over a coincident button press
                if (!set_mode_s) begin
                    state_next = ST_RUN;
                end else if (btn_rise) begin
                    do_inc        = 1'b1;
                    hold_cnt_next = HOLD_ZERO;
                    state_next    = ST_SET_HELD;
                end
            end
            ST_SET_HELD: begin
                if (!set_mode_s) begin
                    state_next = ST_RUN;
                end else if (!sync_btn) begin
                    state_next = ST_SET_IDLE;
                end else if (enable_1hz) begin
                    if (hold_cnt_reg < HOLD_LIM) hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                    else                         do_inc        = 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        blink_next = blink_reg;
        if (state_next == ST_RUN)
            blink_next = 1'b1;
        else if (state_next == ST_SET_IDLE && state_reg != ST_SET_IDLE)
            blink_next = 1'b1;
        else if (enable_1hz)
            blink_next = ~blink_reg;
    end

    always_ff @(posedge maqm_clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            hold_cnt_reg   <= HOLD_ZERO;
            lsd_reg        <= RST_LSD;
            msd_reg        <= RST_MSD;
            blink_reg      <= 1'b1;
            set_active_reg <= 1'b0;
            prev_btn_reg   <= 1'b0;
`ifdef TWELVE_HOUR_EN
            pm_reg         <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            blink_reg      <= blink_next;
            set_active_reg <= (state_next != ST_RUN);
            prev_btn_reg   <= sync_btn;
            if (do_inc) begin
                lsd_reg <= inc_lsd;
                msd_reg <= inc_msd;
`ifdef TWELVE_HOUR_EN
                pm_reg  <= inc_pm;
`endif
            end
        end
    end

    assign maqh_lsd   = lsd_reg;
    assign maqh_msd   = msd_reg;
    assign set_active = set_active_reg;
    assign blink_on   = blink_reg;

`ifdef TWELVE_HOUR_EN
    assign maqh_pm      = pm_reg;
    assign maqh_inc_dia = (msd_reg == 2'd1) & (lsd_reg == 4'd1) & pm_reg
                          & maqh_inc_hora & (state_reg == ST_RUN);
`else
    assign maqh_inc_dia = (msd_reg == 2'd2) & (lsd_reg == 4'd3)
                          & maqh_inc_hora & (state_reg == ST_RUN);
`endif

endmodule
